// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Two-stage valid/ready pipeline computing one of eight bitwise functions
//   on two WIDTH-bit operands, with an optional running-XOR accumulator.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents a transaction
//   in_ready   unit accepts the transaction this cycle (combinational)
//   op         function select, captured on accept
//   acc_mode   fold the result into the accumulator, captured on accept
//   acc_clr    zero the accumulator before folding, captured on accept
//   a, b       operands
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   f          result
//   parity     XOR-reduction of f
//   acc        current accumulator value
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    // Stage 1: captured transaction
    logic             s1_valid;
    op_e              s1_op;
    logic             s1_acc_mode;
    logic             s1_acc_clr;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_adv;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] f_next;
    logic [WIDTH-1:0] acc_next;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_comb begin
        res = s1_a;
        case (s1_op)
            OP_AND:   res = s1_a & s1_b;
            OP_OR:    res = s1_a | s1_b;
            OP_XOR:   res = s1_a ^ s1_b;
            OP_NAND:  res = ~(s1_a & s1_b);
            OP_NOR:   res = ~(s1_a | s1_b);
            OP_XNOR:  res = ~(s1_a ^ s1_b);
            OP_NOTA:  res = ~s1_a;
            OP_PASSA: res = s1_a;
            default:  res = s1_a;
        endcase
    end

    // Accumulator fold; in plain-accumulate mode the presented result is
    // the updated accumulator rather than the raw op result.
    always_comb begin
        acc_next = acc;
        f_next   = res;
        if (s1_acc_mode) begin
            if (s1_acc_clr) begin
                acc_next = res;
            end else begin
                acc_next = acc ^ res;
                f_next   = acc ^ res;
            end
        end else if (s1_acc_clr) begin
            acc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_AND;
            s1_acc_mode <= 1'b0;
            s1_acc_clr  <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op       <= op_e'(op);
                s1_acc_mode <= acc_mode;
                s1_acc_clr  <= acc_clr;
                s1_a        <= a;
                s1_b        <= b;
            end
        end
    end

    // acc only moves on a stage-1 to stage-2 transfer, so a transaction
    // stalled in stage 1 folds exactly once, when it finally advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            parity    <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f      <= f_next;
                parity <= ^f_next;
                acc    <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
module tb_bitwise_logic_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        acc_mode;
    logic        acc_clr;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        parity;
    logic [15:0] acc;

    logic        iv8, ir8, am8, ac8, ov8, or8, p8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, f8, acc8;

    int checks = 0;
    int failures = 0;

    bitwise_logic_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .parity(parity),
        .acc(acc)
    );

    bitwise_logic_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .op(op8), .acc_mode(am8), .acc_clr(ac8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .f(f8), .parity(p8), .acc(acc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] f;
        logic        p;
        logic [15:0] acc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] macc;
    logic        hold_pend;
    logic [15:0] held_f;

    function automatic logic [15:0] opres(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] tbl [8];
        tbl[0] = x & y;   tbl[1] = x | y;     tbl[2] = x ^ y;  tbl[3] = ~(x & y);
        tbl[4] = ~(x | y); tbl[5] = ~(x ^ y); tbl[6] = ~x;     tbl[7] = x;
        return tbl[o];
    endfunction

    // Transactions fold in acceptance order, so the expected acc shown with
    // each result is the running fold up to and including that transaction.
    task automatic model_push(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                              input logic m, input logic c);
        exp_t e;
        logic [15:0] r;
        r = opres(o, x, y);
        e.f = r;
        if (m && c)       macc = r;
        else if (m)       begin macc = macc ^ r; e.f = macc; end
        else if (c)       macc = '0;
        e.p = ^e.f;
        e.acc = macc;
        q.push_back(e);
    endtask

    task automatic model_flush();
        q.delete();
        macc = '0;
        hold_pend = 1'b0;
    endtask

    initial begin
        macc = '0;
        hold_pend = 1'b0;
        held_f = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_f", {16'd0, f}, {16'd0, held_f});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=f:%h required=no output", f);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_f", {16'd0, f}, {16'd0, e.f});
                    chk("sb_parity", {31'd0, parity}, {31'd0, e.p});
                    chk("sb_acc", {16'd0, acc}, {16'd0, e.acc});
                end
            end
            if (in_valid && in_ready) model_push(op, a, b, acc_mode, acc_clr);
            hold_pend = out_valid && !out_ready;
            held_f = f;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        c;
        logic [15:0] ef;
        logic        ep;
        logic [15:0] eacc;
    } vec_t;

    vec_t vt [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{3'b010, 16'habab, 16'hffff, 1'b0, 1'b0, 16'h5454, 1'b0, 16'h0000};
        vt[1]  = '{3'b010, 16'h0101, 16'h5555, 1'b0, 1'b0, 16'h5454, 1'b0, 16'h0000};
        vt[2]  = '{3'b000, 16'habab, 16'hffff, 1'b0, 1'b0, 16'habab, 1'b0, 16'h0000};
        vt[3]  = '{3'b001, 16'habab, 16'hffff, 1'b0, 1'b0, 16'hffff, 1'b0, 16'h0000};
        vt[4]  = '{3'b010, 16'habab, 16'hffff, 1'b0, 1'b0, 16'h5454, 1'b0, 16'h0000};
        vt[5]  = '{3'b011, 16'habab, 16'hffff, 1'b0, 1'b0, 16'h5454, 1'b0, 16'h0000};
        vt[6]  = '{3'b100, 16'habab, 16'hffff, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[7]  = '{3'b101, 16'habab, 16'hffff, 1'b0, 1'b0, 16'habab, 1'b0, 16'h0000};
        vt[8]  = '{3'b110, 16'habab, 16'hffff, 1'b0, 1'b0, 16'h5454, 1'b0, 16'h0000};
        vt[9]  = '{3'b111, 16'habab, 16'hffff, 1'b0, 1'b0, 16'habab, 1'b0, 16'h0000};
        vt[10] = '{3'b010, 16'habab, 16'hffff, 1'b1, 1'b1, 16'h5454, 1'b0, 16'h5454};
        vt[11] = '{3'b010, 16'h0101, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[12] = '{3'b111, 16'h00ff, 16'h0000, 1'b1, 1'b0, 16'h00ff, 1'b0, 16'h00ff};
        vt[13] = '{3'b111, 16'h0001, 16'h1234, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h00ff};
        vt[14] = '{3'b000, 16'hffff, 16'hffff, 1'b0, 1'b1, 16'hffff, 1'b0, 16'h0000};

        rst_n = 1'b0;
        in_valid = 1'b0; op = '0; acc_mode = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
        out_ready = 1'b1;
        iv8 = 1'b0; op8 = '0; am8 = 1'b0; ac8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_f", {16'd0, f}, 32'd0);
        chk("rst_parity", {31'd0, parity}, 32'd0);
        chk("rst_acc", {16'd0, acc}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        tick();

        // Table: one transaction at a time, checking one-cycle latency.
        for (int i = 0; i < 15; i++) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b;
            acc_mode = vt[i].m; acc_clr = vt[i].c; in_valid = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_not_yet_valid", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_f", i), {16'd0, f}, {16'd0, vt[i].ef});
            chk($sformatf("vec%0d_parity", i), {31'd0, parity}, {31'd0, vt[i].ep});
            chk($sformatf("vec%0d_acc", i), {16'd0, acc}, {16'd0, vt[i].eacc});
            tick();
        end

        // WIDTH=8 instance
        iv8 = 1'b1; op8 = 3'b100; a8 = 8'h0f; b8 = 8'h30;
        tick();
        iv8 = 1'b0;
        tick();
        chk("w8_nor_valid", {31'd0, ov8}, 32'd1);
        chk("w8_nor_f", {24'd0, f8}, 32'h0000_00c0);
        chk("w8_nor_parity", {31'd0, p8}, 32'd0);
        iv8 = 1'b1; op8 = 3'b110; a8 = 8'h01; b8 = 8'h00;
        tick();
        iv8 = 1'b0;
        tick();
        chk("w8_nota_f", {24'd0, f8}, 32'h0000_00fe);
        chk("w8_nota_parity", {31'd0, p8}, 32'd1);
        tick();

        // Backpressure: three back-to-back accumulating transactions.
        out_ready = 1'b0;
        op = 3'b010; a = 16'habab; b = 16'hffff; acc_mode = 1'b1; acc_clr = 1'b1; in_valid = 1'b1;
        tick();
        op = 3'b001; a = 16'h0f0f; b = 16'h00f0; acc_clr = 1'b0;
        chk("bp_second_ready", {31'd0, in_ready}, 32'd1);
        tick();
        op = 3'b000; a = 16'hffff; b = 16'h1234;
        chk("bp_third_blocked", {31'd0, in_ready}, 32'd0);
        chk("bp_first_f", {16'd0, f}, 32'h5454);
        chk("bp_first_acc", {16'd0, acc}, 32'h5454);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_stall_f", {16'd0, f}, 32'h5454);
            chk("bp_stall_acc", {16'd0, acc}, 32'h5454);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_f", {16'd0, f}, 32'h5bab);
        chk("bp_second_acc", {16'd0, acc}, 32'h5bab);
        tick();
        chk("bp_third_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_third_f", {16'd0, f}, 32'h499f);
        chk("bp_third_acc", {16'd0, acc}, 32'h499f);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_acc_hold", {16'd0, acc}, 32'h499f);

        // Reset mid-flight with two transactions held.
        out_ready = 1'b0;
        op = 3'b111; a = 16'h0007; b = 16'h0000; acc_mode = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0070;
        tick();
        in_valid = 1'b0;
        chk("mid_held_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        model_flush();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_f", {16'd0, f}, 32'd0);
        chk("mid_rst_parity", {31'd0, parity}, 32'd0);
        chk("mid_rst_acc", {16'd0, acc}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Randomised traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            op        = 3'($urandom_range(0, 7));
            a         = 16'($urandom);
            b         = 16'($urandom);
            acc_mode  = $urandom_range(0, 1) == 1;
            acc_clr   = ($urandom_range(0, 9) == 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("rand_drain_empty", q.size(), 32'd0);
        chk("rand_drain_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
